// File: rtl/tl_pkg.sv
// Shared TileLink opcode constants and beat-count helpers for the memory arbiter.
package tl_pkg;

  localparam logic [2:0] TL_A_GET              = 3'd4;
  localparam logic [2:0] TL_A_PUT_FULL         = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL      = 3'd1;
  localparam logic [2:0] TL_D_ACCESS_ACK       = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA  = 3'd1;

  // One beat carries 8 bytes, so sizes above 3 span 2^(size-3) beats.
  function automatic logic [4:0] tl_beats_from_size(input logic [2:0] size);
    if (size > 3'd3) return 5'd1 << (size - 3'd3);
    return 5'd1;
  endfunction

  function automatic logic [4:0] tl_a_beats(input logic [2:0] opcode, input logic [2:0] size);
    case (opcode)
      TL_A_PUT_FULL, TL_A_PUT_PARTIAL: return tl_beats_from_size(size);
      TL_A_GET:                        return 5'd1;
      default:                         return 5'd1;
    endcase
  endfunction

  function automatic logic [4:0] tl_d_beats(input logic [2:0] opcode, input logic [2:0] size);
    case (opcode)
      TL_D_ACCESS_ACK_DATA: return tl_beats_from_size(size);
      TL_D_ACCESS_ACK:      return 5'd1;
      default:              return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin pick: lowest requesting index at or above the pointer, else lowest overall.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   ptr_i,
  output logic [1:0]   idx_o,
  output logic         gnt_o
);

  always_comb begin
    idx_o = 2'd0;
    gnt_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = 2'(i);
        gnt_o = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i] && (2'(i) >= ptr_i)) idx_o = 2'(i);
    end
  end

endmodule

// File: rtl/tl_mem_arbiter.sv
// Round-robin TileLink A-channel arbiter onto one memory port, with D-channel routing by source.
module tl_mem_arbiter
  import tl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ*3-1:0]        req_a_opcode_i,
  input  logic [N_REQ*3-1:0]        req_a_param_i,
  input  logic [N_REQ*3-1:0]        req_a_size_i,
  input  logic [N_REQ*2-1:0]        req_a_source_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_a_address_i,
  input  logic [N_REQ*8-1:0]        req_a_mask_i,
  input  logic [N_REQ*DATA_W-1:0]   req_a_data_i,
  input  logic [N_REQ-1:0]          req_a_valid_i,
  output logic [N_REQ-1:0]          req_a_ready_o,
  output logic [N_REQ*3-1:0]        req_d_opcode_o,
  output logic [N_REQ*2-1:0]        req_d_param_o,
  output logic [N_REQ*3-1:0]        req_d_size_o,
  output logic [N_REQ*2-1:0]        req_d_source_o,
  output logic [N_REQ*2-1:0]        req_d_sink_o,
  output logic [N_REQ-1:0]          req_d_denied_o,
  output logic [N_REQ*DATA_W-1:0]   req_d_data_o,
  output logic [N_REQ-1:0]          req_d_corrupt_o,
  output logic [N_REQ-1:0]          req_d_valid_o,
  input  logic [N_REQ-1:0]          req_d_ready_i,
  output logic [2:0]                mem_a_opcode_o,
  output logic [2:0]                mem_a_param_o,
  output logic [2:0]                mem_a_size_o,
  output logic [3:0]                mem_a_source_o,
  output logic [ADDR_W-1:0]         mem_a_address_o,
  output logic [7:0]                mem_a_mask_o,
  output logic [DATA_W-1:0]         mem_a_data_o,
  output logic                      mem_a_valid_o,
  input  logic                      mem_a_ready_i,
  input  logic [2:0]                mem_d_opcode_i,
  input  logic [1:0]                mem_d_param_i,
  input  logic [2:0]                mem_d_size_i,
  input  logic [3:0]                mem_d_source_i,
  input  logic [1:0]                mem_d_sink_i,
  input  logic                      mem_d_denied_i,
  input  logic [DATA_W-1:0]         mem_d_data_i,
  input  logic                      mem_d_corrupt_i,
  input  logic                      mem_d_valid_i,
  output logic                      mem_d_ready_o,
  output logic                      err_o
);

  localparam int              CNT_W    = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
  localparam logic            ST_IDLE  = 1'b0;
  localparam logic            ST_BURST = 1'b1;

  logic             r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_owner;
  logic             r_hold;
  logic [4:0]       r_a_left;
  logic [4:0]       r_d_cnt;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt [N_REQ];

  logic [N_REQ-1:0] w_elig, w_inc, w_dec;
  logic [1:0]       w_rr_idx, w_owner, w_d_idx;
  logic             w_rr_gnt, w_locked, w_have, w_own_valid, w_a_valid, w_a_fire;
  logic             w_first, w_a_last, w_d_bad, w_d_sel_rdy, w_d_fire, w_d_last;
  logic [2:0]       w_op, w_param, w_size;
  logic [1:0]       w_src;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]       w_mask;
  logic [DATA_W-1:0] w_data;
  logic [4:0]       w_a_beats, w_d_beats;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) w_elig[i] = req_a_valid_i[i] && (r_cnt[i] < CNT_MAX);
  end

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i (w_elig),
    .ptr_i (r_ptr),
    .idx_o (w_rr_idx),
    .gnt_o (w_rr_gnt)
  );

  // The owner is frozen during a burst and across any stalled beat.
  assign w_locked = (r_state == ST_BURST) || r_hold;
  assign w_owner  = w_locked ? r_owner : w_rr_idx;
  assign w_have   = w_locked || w_rr_gnt;

  always_comb begin
    w_own_valid = 1'b0;
    w_op = '0; w_param = '0; w_size = '0; w_src = '0;
    w_addr = '0; w_mask = '0; w_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_owner == 2'(i)) begin
        w_own_valid = req_a_valid_i[i];
        w_op    = req_a_opcode_i[i*3 +: 3];
        w_param = req_a_param_i[i*3 +: 3];
        w_size  = req_a_size_i[i*3 +: 3];
        w_src   = req_a_source_i[i*2 +: 2];
        w_addr  = req_a_address_i[i*ADDR_W +: ADDR_W];
        w_mask  = req_a_mask_i[i*8 +: 8];
        w_data  = req_a_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_a_valid = rst_ni && w_have && w_own_valid;
  assign w_a_fire  = w_a_valid && mem_a_ready_i;
  assign w_first   = (r_state == ST_IDLE);
  assign w_a_beats = tl_a_beats(w_op, w_size);
  assign w_a_last  = w_first ? (w_a_beats == 5'd1) : (r_a_left == 5'd1);

  assign mem_a_valid_o   = w_a_valid;
  assign mem_a_opcode_o  = w_op;
  assign mem_a_param_o   = w_param;
  assign mem_a_size_o    = w_size;
  assign mem_a_source_o  = {w_owner, w_src};
  assign mem_a_address_o = w_addr;
  assign mem_a_mask_o    = w_mask;
  assign mem_a_data_o    = w_data;

  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      req_a_ready_o[i] = rst_ni && w_have && (w_owner == 2'(i)) && mem_a_ready_i;
  end

  // D routing: source bits [3:2] carry the requester index added on the A side.
  assign w_d_idx = mem_d_source_i[3:2];
  assign w_d_bad = int'(w_d_idx) >= N_REQ;

  always_comb begin
    w_d_sel_rdy = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_d_idx == 2'(i)) w_d_sel_rdy = req_d_ready_i[i];
      req_d_valid_o[i] = rst_ni && mem_d_valid_i && !w_d_bad && (w_d_idx == 2'(i));
    end
  end

  assign mem_d_ready_o   = w_d_bad || w_d_sel_rdy;
  assign w_d_fire        = mem_d_valid_i && mem_d_ready_o;
  assign w_d_beats       = tl_d_beats(mem_d_opcode_i, mem_d_size_i);
  assign w_d_last        = (r_d_cnt == (w_d_beats - 5'd1));
  assign err_o           = r_err;

  assign req_d_opcode_o  = {N_REQ{mem_d_opcode_i}};
  assign req_d_param_o   = {N_REQ{mem_d_param_i}};
  assign req_d_size_o    = {N_REQ{mem_d_size_i}};
  assign req_d_source_o  = {N_REQ{mem_d_source_i[1:0]}};
  assign req_d_sink_o    = {N_REQ{mem_d_sink_i}};
  assign req_d_denied_o  = {N_REQ{mem_d_denied_i}};
  assign req_d_data_o    = {N_REQ{mem_d_data_i}};
  assign req_d_corrupt_o = {N_REQ{mem_d_corrupt_i}};

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_inc[i] = w_a_fire && w_first && (w_owner == 2'(i));
      w_dec[i] = w_d_fire && w_d_last && !w_d_bad && (w_d_idx == 2'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 2'd0;
      r_owner  <= 2'd0;
      r_hold   <= 1'b0;
      r_a_left <= 5'd0;
      r_d_cnt  <= 5'd0;
      r_err    <= 1'b0;
      for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
    end else begin
      r_hold <= w_a_valid && !mem_a_ready_i;
      if (w_first && w_a_valid) r_owner <= w_owner;
      if (w_a_fire) begin
        if (w_a_last) begin
          r_state  <= ST_IDLE;
          r_a_left <= 5'd0;
          r_ptr    <= (w_owner == 2'(N_REQ - 1)) ? 2'd0 : w_owner + 2'd1;
        end else if (w_first) begin
          r_state  <= ST_BURST;
          r_a_left <= w_a_beats - 5'd1;
        end else begin
          r_a_left <= r_a_left - 5'd1;
        end
      end
      if (w_d_fire) r_d_cnt <= w_d_last ? 5'd0 : r_d_cnt + 5'd1;
      if (mem_d_valid_i && w_d_bad) r_err <= 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (w_inc[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tl_mem_arbiter.sv
// Directed bench for tl_mem_arbiter: a 4-requester instance plus a 3-requester instance for bad-source routing.
module tb_tl_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [11:0]  a_op, a_param, a_size;
  logic [7:0]   a_src;
  logic [255:0] a_addr, a_data;
  logic [31:0]  a_mask;
  logic [3:0]   a_valid, a_ready;
  logic [11:0]  d_op, d_size;
  logic [7:0]   d_param, d_src, d_sink;
  logic [3:0]   d_denied, d_corrupt, d_valid, d_ready;
  logic [255:0] d_data;
  logic [2:0]   ma_op, ma_param, ma_size;
  logic [3:0]   ma_src;
  logic [63:0]  ma_addr, ma_data;
  logic [7:0]   ma_mask;
  logic         ma_valid, ma_ready;
  logic [2:0]   md_op, md_size;
  logic [1:0]   md_param, md_sink;
  logic [3:0]   md_src;
  logic         md_denied, md_corrupt, md_valid, md_ready, err;
  logic [63:0]  md_data;

  tl_mem_arbiter #(.N_REQ(4), .ADDR_W(64), .DATA_W(64), .MAX_OUT(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_a_opcode_i(a_op), .req_a_param_i(a_param), .req_a_size_i(a_size),
    .req_a_source_i(a_src), .req_a_address_i(a_addr), .req_a_mask_i(a_mask),
    .req_a_data_i(a_data), .req_a_valid_i(a_valid), .req_a_ready_o(a_ready),
    .req_d_opcode_o(d_op), .req_d_param_o(d_param), .req_d_size_o(d_size),
    .req_d_source_o(d_src), .req_d_sink_o(d_sink), .req_d_denied_o(d_denied),
    .req_d_data_o(d_data), .req_d_corrupt_o(d_corrupt), .req_d_valid_o(d_valid),
    .req_d_ready_i(d_ready),
    .mem_a_opcode_o(ma_op), .mem_a_param_o(ma_param), .mem_a_size_o(ma_size),
    .mem_a_source_o(ma_src), .mem_a_address_o(ma_addr), .mem_a_mask_o(ma_mask),
    .mem_a_data_o(ma_data), .mem_a_valid_o(ma_valid), .mem_a_ready_i(ma_ready),
    .mem_d_opcode_i(md_op), .mem_d_param_i(md_param), .mem_d_size_i(md_size),
    .mem_d_source_i(md_src), .mem_d_sink_i(md_sink), .mem_d_denied_i(md_denied),
    .mem_d_data_i(md_data), .mem_d_corrupt_i(md_corrupt), .mem_d_valid_i(md_valid),
    .mem_d_ready_o(md_ready), .err_o(err)
  );

  logic [8:0]   a3_op, a3_param, a3_size, d3_op, d3_size;
  logic [5:0]   a3_src, d3_param, d3_src, d3_sink;
  logic [191:0] a3_addr, a3_data, d3_data;
  logic [23:0]  a3_mask;
  logic [2:0]   a3_valid, a3_ready, d3_denied, d3_corrupt, d3_valid, d3_ready;
  logic [2:0]   m3a_op, m3a_param, m3a_size;
  logic [3:0]   m3a_src, m3d_src;
  logic [63:0]  m3a_addr, m3a_data;
  logic [7:0]   m3a_mask;
  logic         m3a_valid, m3d_valid, m3d_ready, err3;

  tl_mem_arbiter #(.N_REQ(3), .ADDR_W(64), .DATA_W(64), .MAX_OUT(2)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_a_opcode_i(a3_op), .req_a_param_i(a3_param), .req_a_size_i(a3_size),
    .req_a_source_i(a3_src), .req_a_address_i(a3_addr), .req_a_mask_i(a3_mask),
    .req_a_data_i(a3_data), .req_a_valid_i(a3_valid), .req_a_ready_o(a3_ready),
    .req_d_opcode_o(d3_op), .req_d_param_o(d3_param), .req_d_size_o(d3_size),
    .req_d_source_o(d3_src), .req_d_sink_o(d3_sink), .req_d_denied_o(d3_denied),
    .req_d_data_o(d3_data), .req_d_corrupt_o(d3_corrupt), .req_d_valid_o(d3_valid),
    .req_d_ready_i(d3_ready),
    .mem_a_opcode_o(m3a_op), .mem_a_param_o(m3a_param), .mem_a_size_o(m3a_size),
    .mem_a_source_o(m3a_src), .mem_a_address_o(m3a_addr), .mem_a_mask_o(m3a_mask),
    .mem_a_data_o(m3a_data), .mem_a_valid_o(m3a_valid), .mem_a_ready_i(1'b1),
    .mem_d_opcode_i(3'd0), .mem_d_param_i(2'd0), .mem_d_size_i(3'd0),
    .mem_d_source_i(m3d_src), .mem_d_sink_i(2'd0), .mem_d_denied_i(1'b0),
    .mem_d_data_i(64'd0), .mem_d_corrupt_i(1'b0), .mem_d_valid_i(m3d_valid),
    .mem_d_ready_o(m3d_ready), .err_o(err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input int r, input logic [2:0] op, input logic [2:0] sz,
                       input logic [1:0] src, input logic [63:0] addr, input logic v);
    a_op[r*3 +: 3]    = op;
    a_size[r*3 +: 3]  = sz;
    a_src[r*2 +: 2]   = src;
    a_addr[r*64 +: 64] = addr;
    a_data[r*64 +: 64] = {32'hDA7A0000, 32'(r)};
    a_mask[r*8 +: 8]  = 8'hFF;
    a_valid[r]        = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = '0;
    md_valid = 1'b0;
    ma_ready = 1'b1;
    d_ready = 4'hF;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    a_op = '0; a_param = '0; a_size = '0; a_src = '0; a_addr = '0; a_data = '0;
    a_mask = '0; a_valid = '0; d_ready = 4'hF; ma_ready = 1'b1;
    md_op = '0; md_param = '0; md_size = '0; md_src = '0; md_sink = '0;
    md_denied = 1'b0; md_data = 64'h1234; md_corrupt = 1'b0; md_valid = 1'b0;
    a3_op = '0; a3_param = '0; a3_size = '0; a3_src = '0; a3_addr = '0; a3_data = '0;
    a3_mask = '0; a3_valid = '0; d3_ready = '0; m3d_src = '0; m3d_valid = 1'b0;

    // Reset: outputs held quiet even with a valid requester and a D beat present.
    set_a(0, 3'd4, 3'd6, 2'd0, 64'h100, 1'b1);
    md_valid = 1'b1; md_src = 4'h0;
    tick();
    tick();
    chk("rst_mem_a_valid", 64'(ma_valid), 64'd0);
    chk("rst_req_a_ready", 64'(a_ready), 64'd0);
    chk("rst_req_d_valid", 64'(d_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    a_valid = '0; md_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Requesters 0 and 2 issue the same Get; 0 first, then 2.
    set_a(0, 3'd4, 3'd6, 2'd0, 64'h100, 1'b1);
    set_a(2, 3'd4, 3'd6, 2'd0, 64'h100, 1'b1);
    #1;
    chk("get_r0_valid", 64'(ma_valid), 64'd1);
    chk("get_r0_source", 64'(ma_src), 64'h0);
    chk("get_r0_ready", 64'(a_ready), 64'b0001);
    chk("get_r0_addr", ma_addr, 64'h100);
    chk("get_r0_opcode", 64'(ma_op), 64'd4);
    tick();
    a_valid[0] = 1'b0;
    #1;
    chk("get_r2_source", 64'(ma_src), 64'h8);
    chk("get_r2_ready", 64'(a_ready), 64'b0100);
    tick();
    a_valid[2] = 1'b0;
    md_valid = 1'b1; md_op = 3'd1; md_size = 3'd6; md_src = 4'h8;
    d_ready[2] = 1'b0;
    #1;
    chk("d_r2_backpressure", 64'(md_ready), 64'd0);
    d_ready[2] = 1'b1;
    for (int b = 0; b < 8; b++) begin
      #1;
      chk($sformatf("d_r2_valid_b%0d", b), 64'(d_valid), 64'b0100);
      tick();
    end
    chk("d_r2_ready", 64'(md_ready), 64'd1);
    chk("d_r2_source", 64'(d_src[5:4]), 64'd0);
    md_valid = 1'b0;

    // 8-beat PutFullData from 1 with 3 also valid; stall on beat 4 keeps owner.
    do_reset();
    set_a(1, 3'd0, 3'd6, 2'd1, 64'h200, 1'b1);
    set_a(3, 3'd4, 3'd3, 2'd2, 64'h300, 1'b1);
    #1;
    chk("put_r1_source", 64'(ma_src), 64'h5);
    chk("put_r1_data", ma_data, 64'hDA7A000000000001);
    for (int b = 1; b <= 8; b++) begin
      if (b == 4) begin
        ma_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk($sformatf("put_stall_src_%0d", s), 64'(ma_src), 64'h5);
          chk($sformatf("put_stall_rdy_%0d", s), 64'(a_ready), 64'b0000);
          tick();
        end
        ma_ready = 1'b1;
      end
      #1;
      chk($sformatf("put_beat%0d_ready", b), 64'(a_ready), 64'b0010);
      tick();
    end
    a_valid[1] = 1'b0;
    #1;
    chk("put_then_r3_ready", 64'(a_ready), 64'b1000);
    chk("put_then_r3_source", 64'(ma_src), 64'hE);
    tick();
    a_valid[3] = 1'b0;

    // Reset during beat 5 of a burst; full counts for 2 must also clear.
    do_reset();
    set_a(2, 3'd4, 3'd3, 2'd0, 64'h400, 1'b1);
    tick();
    tick();
    #1;
    chk("r2_full_blocked", 64'(ma_valid), 64'd0);
    set_a(1, 3'd0, 3'd6, 2'd0, 64'h500, 1'b1);
    for (int b = 1; b <= 4; b++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_a_valid", 64'(ma_valid), 64'd0);
    chk("midrst_req_a_ready", 64'(a_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    a_valid[1] = 1'b0;
    set_a(0, 3'd4, 3'd3, 2'd0, 64'h600, 1'b1);
    #1;
    chk("postrst_r0_wins", 64'(a_ready), 64'b0001);
    tick();
    a_valid[0] = 1'b0;
    #1;
    chk("postrst_r2_count_cleared", 64'(a_ready), 64'b0100);
    tick();
    a_valid[2] = 1'b0;

    // Outstanding limit: third Get from 0 waits for a complete 8-beat response.
    do_reset();
    set_a(0, 3'd4, 3'd6, 2'd0, 64'h700, 1'b1);
    #1;
    chk("lim_get1_ready", 64'(a_ready), 64'b0001);
    tick();
    chk("lim_get2_ready", 64'(a_ready), 64'b0001);
    tick();
    chk("lim_get3_blocked", 64'(ma_valid), 64'd0);
    md_valid = 1'b1; md_op = 3'd1; md_size = 3'd6; md_src = 4'h0;
    for (int b = 0; b < 8; b++) begin
      #1;
      if (b == 7) chk("lim_blocked_last_beat", 64'(ma_valid), 64'd0);
      tick();
    end
    md_valid = 1'b0;
    #1;
    chk("lim_get3_released", 64'(a_ready), 64'b0001);
    a_valid[0] = 1'b0;

    // Nonexistent requester on the 3-way instance: drained and flagged until reset.
    m3d_valid = 1'b1; m3d_src = 4'hC;
    #1;
    chk("bad_src_d_ready", 64'(m3d_ready), 64'd1);
    chk("bad_src_no_valid", 64'(d3_valid), 64'd0);
    tick();
    m3d_valid = 1'b0;
    tick();
    tick();
    chk("bad_src_err_sticky", 64'(err3), 64'd1);
    do_reset();
    chk("bad_src_err_cleared", 64'(err3), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
